// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. Owns the PC,
//   requests words from an instruction memory with a ready handshake, and
//   presents {curr_pc_fd, curr_instr_fd, valid_fd} to decode. Decode can hold
//   the stage (stall) or redirect it to a branch target (flush). Fetching a
//   HLT word freezes the stage until a flush or reset.
//
// Ports
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   synchronous active-low reset
//   stall          in   1   hold PC and IF/ID this cycle
//   flush          in   1   redirect to branch_pc, squash IF/ID
//   branch_pc      in   16  redirect target, valid with flush
//   imem_req       out  1   fetch request (FETCH and WAIT states)
//   imem_addr      out  16  fetch address, always the PC register
//   imem_rdy       in   1   imem_data valid for imem_addr this cycle
//   imem_data      in   16  instruction word
//   curr_pc_fd     out  16  PC of the instruction in IF/ID
//   curr_instr_fd  out  16  instruction in IF/ID
//   valid_fd       out  1   IF/ID holds a real instruction
//   halted         out  1   stage is frozen on HLT
//   wait_cnt       out  16  saturating count of cycles spent in WAIT
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'hE000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] curr_pc_fd,
    output logic [15:0] curr_instr_fd,
    output logic        valid_fd,
    output logic        halted,
    output logic [15:0] wait_cnt
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e      state_q,    state_d;
    logic [15:0] pc_q,       pc_d;
    logic [15:0] pc_fd_q,    pc_fd_d;
    logic [15:0] instr_fd_q, instr_fd_d;
    logic        valid_fd_q, valid_fd_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Next-state logic. Priority: flush > stall > normal fetch progress.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pc_fd_d    = pc_fd_q;
        instr_fd_d = instr_fd_q;
        valid_fd_d = valid_fd_q;

        if (flush) begin
            // Redirect from any state; any pending or same-cycle word is dropped.
            state_d    = S_FETCH;
            pc_d       = branch_pc;
            pc_fd_d    = branch_pc;
            instr_fd_d = NOP_INSTR;
            valid_fd_d = 1'b0;
        end else if (stall) begin
            // PC and IF/ID hold; a missing word still moves FETCH into WAIT.
            // A ready word is ignored here and refetched once the stall drops.
            if (state_q == S_FETCH && !imem_rdy) begin
                state_d = S_WAIT;
            end
        end else begin
            unique case (state_q)
                S_FETCH, S_WAIT: begin
                    if (imem_rdy) begin
                        pc_fd_d    = pc_q;
                        instr_fd_d = imem_data;
                        valid_fd_d = 1'b1;
                        if (imem_data[15:12] == HLT_OPCODE) begin
                            state_d = S_HALTED;
                        end else begin
                            state_d = S_FETCH;
                            pc_d    = pc_q + 16'd2;
                        end
                    end else begin
                        state_d    = S_WAIT;
                        pc_fd_d    = pc_q;
                        instr_fd_d = NOP_INSTR;
                        valid_fd_d = 1'b0;
                    end
                end
                S_HALTED: begin
                    // Frozen with the HLT word visible to decode.
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Counts every cycle spent in WAIT, regardless of stall/flush.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_WAIT && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_fd_q    <= RESET_PC;
            instr_fd_q <= NOP_INSTR;
            valid_fd_q <= 1'b0;
            wait_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_fd_q    <= pc_fd_d;
            instr_fd_q <= instr_fd_d;
            valid_fd_q <= valid_fd_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign imem_req      = (state_q != S_HALTED);
    assign imem_addr     = pc_q;
    assign curr_pc_fd    = pc_fd_q;
    assign curr_instr_fd = instr_fd_q;
    assign valid_fd      = valid_fd_q;
    assign halted        = (state_q == S_HALTED);
    assign wait_cnt      = wait_cnt_q;

endmodule
